// File: rtl/spike_event_packer_pkg.sv
// Shared word-format constants and helpers for the spike event packer and
// for any host logic that decodes the packed FIFO words.
package spike_event_packer_pkg;

   localparam int unsigned WORD_W     = 16;
   localparam int unsigned MARKER_BIT = 15;
   localparam int unsigned IDX_LSB    = 8;
   localparam int unsigned IDX_W      = 7;
   localparam int unsigned MN_BIT     = 7;
   localparam int unsigned IA_BIT     = 6;
   localparam int unsigned FRAME_W    = 15;
   localparam int unsigned CNT_W      = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      WR_NONE,
      WR_EVENT,
      WR_MARKER
   } wr_sel_e;

   function automatic word_t make_event(input logic [IDX_W-1:0] idx,
                                        input logic mn, input logic ia);
      word_t w;
      w                   = '0;
      w[IDX_LSB +: IDX_W] = idx;
      w[MN_BIT]           = mn;
      w[IA_BIT]           = ia;
      return w;
   endfunction

   function automatic word_t make_marker(input logic [FRAME_W-1:0] frame);
      word_t w;
      w               = '0;
      w[MARKER_BIT]   = 1'b1;
      w[FRAME_W-1:0]  = frame;
      return w;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(inc);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/spike_event_packer_if.sv
// Spike sampling inputs and host readout port of the spike event packer.
interface spike_event_packer_if
   import spike_event_packer_pkg::*;
#(
   parameter int unsigned NN = 8,
   parameter int unsigned AW = 4
);
   logic [NN:0]        neuronIndex;
   logic               sample_en;
   logic               frame_start;
   logic               MN_spike;
   logic               Ia_spike;
   logic               clear;
   logic               rd_en;
   logic [WORD_W-1:0]  rd_data;
   logic               rd_valid;
   logic [AW:0]        word_count;
   logic               overflow;
   logic [CNT_W-1:0]   dropped_cnt;

   modport slave (
      input  neuronIndex, sample_en, frame_start, MN_spike, Ia_spike, clear, rd_en,
      output rd_data, rd_valid, word_count, overflow, dropped_cnt
   );

   modport master (
      output neuronIndex, sample_en, frame_start, MN_spike, Ia_spike, clear, rd_en,
      input  rd_data, rd_valid, word_count, overflow, dropped_cnt
   );
endinterface

// File: rtl/spike_event_packer_sync_fifo16.sv
// 16-bit synchronous FIFO, 2^AW deep, with one-extra-bit pointers; the
// storage array is deliberately left unreset so it maps onto RAM.
module sync_fifo16
   import spike_event_packer_pkg::*;
#(
   parameter int unsigned AW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);

   logic [AW:0]       wr_q, wr_d;
   logic [AW:0]       rd_q, rd_d;
   logic              push_ok;
   logic              pop_ok;
   logic [WORD_W-1:0] mem [2**AW];

   assign count = wr_q - rd_q;
   assign full  = count[AW];
   assign empty = (count == '0);
   assign dout  = mem[rd_q[AW-1:0]];

   // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
   assign pop_ok  = pop & ~empty & ~clear;
   assign push_ok = push & (~full | pop_ok) & ~clear;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (clear) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push_ok) wr_d = wr_q + 1'b1;
         if (pop_ok)  rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/spike_event_packer.sv
// Packs per-slot motoneuron/Ia spikes and per-sweep frame markers into 16-bit
// words, buffers them in a FIFO for host readout and counts dropped words.
module spike_event_packer
   import spike_event_packer_pkg::*;
#(
   parameter int unsigned NN = 8,
   parameter int unsigned AW = 4
) (
   input logic                  neuron_clk,
   input logic                  reset_sim_n,
   spike_event_packer_if.slave  bus
);

   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   dropped_q, dropped_d;

   wr_sel_e            wr_sel;
   logic               spike_hit;
   logic               collide;
   logic               push;
   logic               pop_ok;
   logic               full_drop;
   logic [IDX_W-1:0]   idx_field;
   word_t              wr_word;
   word_t              fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic [AW:0]        fifo_count;

   assign spike_hit = bus.sample_en & (bus.MN_spike | bus.Ia_spike);
   assign idx_field = IDX_W'(bus.neuronIndex >> 2);
   assign pop_ok    = bus.rd_en & ~fifo_empty;

   // Marker wins a same-cycle collision; clear suppresses both sources.
   always_comb begin
      wr_sel  = WR_NONE;
      collide = 1'b0;
      if (!bus.clear) begin
         if (bus.frame_start) begin
            wr_sel  = WR_MARKER;
            collide = spike_hit;
         end else if (spike_hit) begin
            wr_sel  = WR_EVENT;
         end
      end
   end

   always_comb begin
      wr_word = '0;
      case (wr_sel)
         WR_MARKER: wr_word = make_marker(frame_cnt_q);
         WR_EVENT:  wr_word = make_event(idx_field, bus.MN_spike, bus.Ia_spike);
         default:   wr_word = '0;
      endcase
   end

   assign push      = (wr_sel != WR_NONE);
   assign full_drop = push & fifo_full & ~pop_ok;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      overflow_d  = overflow_q;
      dropped_d   = dropped_q;
      if (bus.clear) begin
         frame_cnt_d = '0;
         overflow_d  = 1'b0;
         dropped_d   = '0;
      end else begin
         if (bus.frame_start) frame_cnt_d = frame_cnt_q + 1'b1;
         if (full_drop)       overflow_d  = 1'b1;
         dropped_d = sat_add(dropped_q, {1'b0, collide} + {1'b0, full_drop});
      end
   end

   always_ff @(posedge neuron_clk or negedge reset_sim_n) begin
      if (!reset_sim_n) begin
         frame_cnt_q <= '0;
         overflow_q  <= 1'b0;
         dropped_q   <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         overflow_q  <= overflow_d;
         dropped_q   <= dropped_d;
      end
   end

   sync_fifo16 #(
      .AW (AW)
   ) u_fifo (
      .clk   (neuron_clk),
      .rst_n (reset_sim_n),
      .clear (bus.clear),
      .push  (push),
      .pop   (bus.rd_en),
      .din   (wr_word),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.rd_data     = fifo_dout;
   assign bus.rd_valid    = ~fifo_empty;
   assign bus.word_count  = fifo_count;
   assign bus.overflow    = overflow_q;
   assign bus.dropped_cnt = dropped_q;

endmodule

// File: tb/tb_spike_event_packer.sv
// Directed self-checking bench for spike_event_packer with hand-computed words.
module tb_spike_event_packer;

   logic neuron_clk = 1'b0;
   logic reset_sim_n;
   int   checks   = 0;
   int   failures = 0;

   spike_event_packer_if #(.NN(8), .AW(4)) bus ();

   spike_event_packer #(
      .NN (8),
      .AW (4)
   ) dut (
      .neuron_clk  (neuron_clk),
      .reset_sim_n (reset_sim_n),
      .bus         (bus)
   );

   always #5 neuron_clk = ~neuron_clk;

   task automatic tick();
      @(posedge neuron_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ev(input logic [8:0] idx, input logic mn, input logic ia);
      bus.sample_en   = 1'b1;
      bus.neuronIndex = idx;
      bus.MN_spike    = mn;
      bus.Ia_spike    = ia;
      tick();
      bus.sample_en   = 1'b0;
      bus.MN_spike    = 1'b0;
      bus.Ia_spike    = 1'b0;
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
   endtask

   task automatic pop();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
   endtask

   initial begin
      reset_sim_n     = 1'b0;
      bus.neuronIndex = '0;
      bus.sample_en   = 1'b0;
      bus.frame_start = 1'b0;
      bus.MN_spike    = 1'b0;
      bus.Ia_spike    = 1'b0;
      bus.clear       = 1'b0;
      bus.rd_en       = 1'b0;
      tick();
      tick();
      chk("rst_count", 32'(bus.word_count), 0);
      chk("rst_valid", 32'(bus.rd_valid), 0);
      chk("rst_ovf", 32'(bus.overflow), 0);
      chk("rst_drop", 32'(bus.dropped_cnt), 0);
      reset_sim_n = 1'b1;
      tick();

      // Frame markers
      frame();
      chk("mk0_valid", 32'(bus.rd_valid), 1);
      chk("mk0_data", 32'(bus.rd_data), 32'h8000);
      chk("mk0_count", 32'(bus.word_count), 1);
      pop();
      chk("mk0_popped", 32'(bus.rd_valid), 0);
      frame();
      chk("mk1_data", 32'(bus.rd_data), 32'h8001);
      pop();

      // Event formatting and silent slot
      ev(9'h1F4, 1'b1, 1'b0);
      chk("ev_mn", 32'(bus.rd_data), 32'h7D80);
      pop();
      ev(9'h1F4, 1'b0, 1'b1);
      chk("ev_ia", 32'(bus.rd_data), 32'h7D40);
      pop();
      ev(9'h1F4, 1'b0, 1'b0);
      chk("ev_silent", 32'(bus.word_count), 0);

      // Overflow: 18 writes into 16 slots
      for (int i = 0; i < 18; i++) ev(9'(i << 2), 1'b1, 1'b0);
      chk("ovf_count", 32'(bus.word_count), 16);
      chk("ovf_flag", 32'(bus.overflow), 1);
      chk("ovf_drop", 32'(bus.dropped_cnt), 2);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("ovf_pop%0d", i), 32'(bus.rd_data), 32'((i << 8) | 32'h80));
         pop();
      end
      chk("ovf_empty", 32'(bus.rd_valid), 0);

      // Clear resets flags and frame counter
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chk("clr_ovf", 32'(bus.overflow), 0);
      chk("clr_drop", 32'(bus.dropped_cnt), 0);
      frame();
      chk("clr_mk", 32'(bus.rd_data), 32'h8000);
      pop();

      // Full FIFO with simultaneous write and pop
      for (int i = 0; i < 16; i++) ev(9'(i << 2), 1'b1, 1'b0);
      chk("fwp_full", 32'(bus.word_count), 16);
      bus.rd_en = 1'b1;
      ev(9'(20 << 2), 1'b1, 1'b0);
      bus.rd_en = 1'b0;
      chk("fwp_count", 32'(bus.word_count), 16);
      chk("fwp_ovf", 32'(bus.overflow), 0);
      chk("fwp_drop", 32'(bus.dropped_cnt), 0);
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("fwp_pop%0d", i), 32'(bus.rd_data), 32'((i << 8) | 32'h80));
         pop();
      end
      chk("fwp_tail", 32'(bus.rd_data), 32'h1480);
      pop();
      chk("fwp_empty", 32'(bus.rd_valid), 0);

      // Marker and spike collide: marker kept, event counted as dropped
      bus.frame_start = 1'b1;
      ev(9'h1F4, 1'b1, 1'b0);
      bus.frame_start = 1'b0;
      chk("col_count", 32'(bus.word_count), 1);
      chk("col_data", 32'(bus.rd_data), 32'h8001);
      chk("col_drop", 32'(bus.dropped_cnt), 1);
      chk("col_ovf", 32'(bus.overflow), 0);
      pop();

      // Write and pop on empty FIFO: write only
      bus.rd_en = 1'b1;
      ev(9'h008, 1'b0, 1'b1);
      bus.rd_en = 1'b0;
      chk("ewp_count", 32'(bus.word_count), 1);
      chk("ewp_data", 32'(bus.rd_data), 32'h0240);
      pop();
      pop();
      chk("empty_pop_ignored", 32'(bus.word_count), 0);

      // Asynchronous reset with 5 words buffered
      for (int i = 0; i < 5; i++) ev(9'(i << 2), 1'b0, 1'b1);
      chk("ar_count5", 32'(bus.word_count), 5);
      reset_sim_n = 1'b0;
      #2;
      chk("ar_count", 32'(bus.word_count), 0);
      chk("ar_valid", 32'(bus.rd_valid), 0);
      chk("ar_drop", 32'(bus.dropped_cnt), 0);
      tick();
      reset_sim_n = 1'b1;
      tick();
      frame();
      chk("ar_mk", 32'(bus.rd_data), 32'h8000);

      // Clear mid-stream, coincident with a spike write
      ev(9'h010, 1'b1, 1'b1);
      ev(9'h014, 1'b1, 1'b0);
      chk("cm_count3", 32'(bus.word_count), 3);
      bus.clear = 1'b1;
      ev(9'h018, 1'b1, 1'b0);
      bus.clear = 1'b0;
      chk("cm_count", 32'(bus.word_count), 0);
      chk("cm_valid", 32'(bus.rd_valid), 0);
      frame();
      chk("cm_mk", 32'(bus.rd_data), 32'h8000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
